// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save stream accumulator.
//   csa_state_e : accumulator FSM states (ACCUM, RESOLVE, DONE)
//   *_DEF       : default DATA_W / ACC_W / CNT_W
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } csa_state_e;

  localparam int DATA_W_DEF = 5;
  localparam int ACC_W_DEF  = 12;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Stream interface of the accumulator.
//   in_valid/in_ready/in_data/in_last : packetised operand stream
//   out_valid/out_ready               : result handshake
//   out_sum/out_count/out_overflow    : packet total, beat count, overflow
// slave  : accumulator side
// master : producer/consumer side
interface csa_stream_accumulator_if
  import csa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/csa_3to2.sv
// Combinational 3:2 compressor.
//   x, y, z       : W-bit operands
//   sum           : x ^ y ^ z
//   carry_shifted : majority(x,y,z) << 1, truncated to W bits
//   carry_out_msb : majority bit W-1, i.e. the carry dropped by the shift
module csa_3to2 #(
  parameter int W = 12
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry_shifted,
  output logic         carry_out_msb
);
  logic [W-1:0] maj;

  assign maj           = (x & y) | (x & z) | (y & z);
  assign sum           = x ^ y ^ z;
  assign carry_shifted = {maj[W-2:0], 1'b0};
  assign carry_out_msb = maj[W-1];
endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand accumulator downstream of the 3-operand carry-save adder.
// Each accepted beat is folded into a redundant sum/carry pair; on the last
// beat the pair is resolved to binary and presented with the beat count and
// an exact overflow flag.
//   clk, rst : clock, asynchronous active-high reset
//   acc_if   : csa_stream_accumulator_if.slave (input stream + result)
// Build option: define CSA_ACC_FAST_RESOLVE_EN to resolve with a single
// ACC_W+1-bit add in one cycle instead of iterating the compressor.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  csa_stream_accumulator_if.slave         acc_if
);
  csa_state_e       state_q;
  logic [ACC_W-1:0] s_q, c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] z_d, csa_sum, csa_carry;
  logic             csa_msb;
  logic             accept;

  // One compressor serves both phases: z carries the new word in ACCUM and
  // is zero in RESOLVE, which reduces it to a half-adder step on s/c.
  assign z_d    = (state_q == ACCUM) ? ACC_W'(acc_if.in_data) : '0;
  assign accept = acc_if.in_valid && (state_q == ACCUM);

  csa_3to2 #(.W(ACC_W)) u_csa (
    .x             (s_q),
    .y             (c_q),
    .z             (z_d),
    .sum           (csa_sum),
    .carry_shifted (csa_carry),
    .carry_out_msb (csa_msb)
  );

`ifdef CSA_ACC_FAST_RESOLVE_EN
  logic [ACC_W:0] fast_sum;
  assign fast_sum = {1'b0, s_q} + {1'b0, c_q};
`endif

  assign acc_if.in_ready     = (state_q == ACCUM);
  assign acc_if.out_valid    = (state_q == DONE);
  assign acc_if.out_sum      = out_sum_q;
  assign acc_if.out_count    = out_cnt_q;
  assign acc_if.out_overflow = out_ovf_q;

  // A carry dropped off the top of the pair is worth exactly 2^ACC_W, so
  // OR-ing every dropped carry into ovf_q keeps the overflow flag exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            s_q   <= csa_sum;
            c_q   <= csa_carry;
            ovf_q <= ovf_q | csa_msb;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (acc_if.in_last) state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
          out_sum_q <= fast_sum[ACC_W-1:0];
          out_ovf_q <= ovf_q | fast_sum[ACC_W];
          out_cnt_q <= cnt_q;
          state_q   <= DONE;
`else
          if (c_q != '0) begin
            s_q   <= csa_sum;
            c_q   <= csa_carry;
            ovf_q <= ovf_q | csa_msb;
          end else begin
            out_sum_q <= s_q;
            out_ovf_q <= ovf_q;
            out_cnt_q <= cnt_q;
            state_q   <= DONE;
          end
`endif
        end
        DONE: begin
          if (acc_if.out_ready) begin
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
module tb_csa_stream_accumulator;
  import csa_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int AW = ACC_W_DEF;
  localparam int CW = CNT_W_DEF;
`ifdef CSA_ACC_FAST_RESOLVE_EN
  localparam int LAT_573 = 2;
`else
  localparam int LAT_573 = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) bus();

  csa_stream_accumulator #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .acc_if (bus)
  );

  typedef struct {
    longint sum;
    longint cnt;
    longint ovf;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  longint m_total = 0;
  longint m_cnt = 0;
  int     ready_mode = 1;  // 0: never ready, 1: always, 2: random
  int     gap_max = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer total of the packet, reduced at the end.
  function automatic exp_t make_exp();
    exp_t e;
    e.sum = m_total % (64'd1 << AW);
    e.cnt = (m_cnt > (64'd1 << CW) - 1) ? (64'd1 << CW) - 1 : m_cnt;
    e.ovf = (m_total >= (64'd1 << AW)) ? 1 : 0;
    return e;
  endfunction

  // Returns at the negedge before the edge on which the beat is taken.
  task automatic send_beat(input int d, input bit l);
    int n;
    n = 0;
    repeat ($urandom_range(0, gap_max)) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = DW'($urandom);
      bus.in_last  = 1'($urandom);
    end
    forever begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(d);
      bus.in_last  = l;
      if (bus.in_ready) break;
      n++;
      if (n > 400) begin
        check("in_ready_timeout", 0, 1);
        return;
      end
    end
    m_total += d;
    m_cnt++;
    if (l) begin
      sb.push_back(make_exp());
      m_total = 0;
      m_cnt   = 0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    m_total = 0;
    m_cnt   = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_out_overflow", bus.out_overflow, 0);
  endtask

  task automatic measure_latency(input string name, input int req);
    int n;
    n = 0;
    idle();
    n = 1;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, n, req);
  endtask

  // Monitor: drives out_ready and scores every result handshake.
  always @(negedge clk) begin : mon
    bit   r;
    exp_t e;
    if (rst) begin
      bus.out_ready = 1'b0;
    end else begin
      case (ready_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0d count %0d, expected no result",
                   bus.out_sum, bus.out_count);
        end else begin
          e = sb.pop_front();
          check("out_sum", bus.out_sum, e.sum);
          check("out_count", bus.out_count, e.cnt);
          check("out_overflow", bus.out_overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    int len;
    bit big;
    longint h_sum, h_cnt, h_ovf;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_in_ready", bus.in_ready, 1);
    check("init_out_valid", bus.out_valid, 0);
    check("init_out_sum", bus.out_sum, 0);

    // 5,7,3 and latency
    send_beat(5, 0);
    send_beat(7, 0);
    send_beat(3, 1);
    measure_latency("latency_5_7_3", LAT_573);
    drain();

    // single beat, carry already zero
    send_beat(31, 1);
    measure_latency("latency_single", 2);
    drain();

    // overflow boundary
    for (int i = 0; i < 133; i++) send_beat(31, i == 132);
    drain();
    for (int i = 0; i < 132; i++) send_beat(31, i == 131);
    drain();

    // back-pressure hold with a word pending on the input
    ready_mode = 0;
    send_beat(4, 1);
    begin
      int n;
      n = 0;
      idle();
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    h_sum = bus.out_sum;
    h_cnt = bus.out_count;
    h_ovf = bus.out_overflow;
    check("hold_sum_model", h_sum, sb[0].sum);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(9);
      bus.in_last  = 1'b1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_sum", bus.out_sum, h_sum);
      check("hold_out_count", bus.out_count, h_cnt);
      check("hold_out_overflow", bus.out_overflow, h_ovf);
    end
    idle();
    ready_mode = 1;
    drain();
    send_beat(9, 1);
    drain();

    // reset mid-packet
    send_beat(4, 0);
    send_beat(6, 0);
    do_reset();
    send_beat(2, 1);
    drain();

    // reset during resolve: no result may appear
    send_beat(5, 0);
    send_beat(7, 0);
    send_beat(3, 1);
    void'(sb.pop_back());
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 0);
    end

    // randomized traffic
    gap_max    = 3;
    ready_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      big = ($urandom_range(0, 99) == 0);
      len = big ? int'($urandom_range(256, 300)) : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++)
        send_beat(big ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 31)), b == len - 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand accumulator that sits directly downstream of the 3-operand carry-save adder.
- Consumes its 5-bit result words as a packetised valid/ready stream.
- Each beat is folded into a redundant sum/carry register pair with one 3:2 compression per cycle.
- On the last beat, resolves the redundant pair iteratively to a binary total, then presents the total, the beat count and an overflow flag on a valid/ready output.

Parameters:
- DATA_W, 5, input word width; matches the carry-save adder result width.
- ACC_W, 12, accumulator width; must be >= DATA_W.
- CNT_W, 8, beat-counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  final beat of the packet; qualified by in_valid.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  packet total, modulo 2^ACC_W.
- out_count  output  CNT_W  beats in the packet; saturates at 2^CNT_W-1.
- out_overflow  output  1  true total exceeded 2^ACC_W-1.

Behaviour:
- Reset (asynchronous, active-high):
  - state=ACCUM; s=0, c=0, count=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 after reset release.
  - Reset asserted mid-packet or mid-resolve discards all partial state.
- States: ACCUM, RESOLVE, DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid and in_ready are both high at a rising edge. On acceptance:
    - s <= s ^ c ^ x
    - c <= maj(s, c, x) << 1, truncated to ACC_W
    - count <= count+1, saturating
    - ovf <= ovf | maj bit ACC_W-1
  - If in_last is high on the accepted beat, go to RESOLVE.
  - Every packet has at least 1 beat; a single-beat packet is legal.
- RESOLVE:
  - in_ready=0.
  - Each cycle with c!=0:
    - s <= s ^ c
    - c <= (s & c) << 1
    - ovf |= (s & c)[ACC_W-1]
  - A cycle with c==0 transitions to DONE and latches out_sum=s, out_count=count, out_overflow=ovf.
  - Latency: at most ACC_W+1 cycles.
- DONE:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On out_valid && out_ready: clear s, c, count and ovf, and go to ACCUM.
  - in_ready rises the cycle after the handshake; there is no same-cycle bypass.
- in_data and in_last are ignored whenever in_ready=0.
- Overflow is exact: out_overflow=1 iff the true unsigned packet total is >= 2^ACC_W.

Optional Feature:
- Macro: CSA_ACC_FAST_RESOLVE_EN.
- Defined: RESOLVE takes exactly 1 cycle.
  - out_sum = s + c, computed with one ACC_W+1-bit add.
  - out_overflow = ovf | carry-out of that add.
  - Then DONE.
- Undefined: the iterative resolve above.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- csa_pkg holds:
  - the state enum (ACCUM, RESOLVE, DONE);
  - default width constants DATA_W_DEF=5, ACC_W_DEF=12, CNT_W_DEF=8.
- Sub-module csa_3to2: parameterised-width combinational compressor, ports x, y, z -> sum, carry_shifted, carry_out_msb.
  - Instantiated once for the ACCUM update.
  - Reused with z=0 for the resolve step.

Test Plan:
- Packet 5, 7, 3 (last on 3), out_ready=1 -> out_sum=15, out_count=3, out_overflow=0. Iterative build: out_valid high 2 cycles after the last-beat edge.
- Single beat 31 with last -> out_sum=31, out_count=1, out_overflow=0. Output follows the first RESOLVE cycle because c==0.
- 133 beats of 31 (true total 4123) -> out_sum=27, out_count=133, out_overflow=1. Same stimulus with 132 beats -> 4092, out_overflow=0.
- Hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and data 9 driven:
  - out_valid and the outputs are held stable, in_ready=0;
  - the word is not absorbed;
  - after the handshake, packet 9 alone gives 9.
- Assert rst mid-packet after beats 4 and 6, then send packet 2 (last) -> out_sum=2, out_count=1. Also asserting rst during RESOLVE yields no out_valid.
- Random in_valid/out_ready gaps over 1000 packets compared to a reference model, run in both CSA_ACC_FAST_RESOLVE_EN builds -> identical out_sum, out_count and out_overflow.
